// File: rtl/regfile_pkg.sv
// Shared definitions for the 16x32 register bank: size defaults, control state
// encoding and the byte-enable width helper.
package regfile_pkg;

  localparam int NREGS_DEF = 16;
  localparam int DW_DEF    = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/regfile_addr_decoder.sv
// Combinational register-index to one-hot decoder with an enable; all zeros when
// en is low.
module regfile_addr_decoder
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [NREGS-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_dec
      assign onehot[gi] = en && (addr == AW'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the register bank: one-stage staged writes with byte enables plus a
// sequenced bulk clear. Build option REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DW-1:0]           wr_data,
  input  logic [be_width(DW)-1:0] wr_be,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic [NREGS-1:0]        wr_onehot,
  output logic                    wr_done,
  output logic [NREGS*DW-1:0]     regs_flat
);

  localparam int BW = be_width(DW);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // Register 0 never reports a commit when it is hardwired.
  localparam logic [NREGS-1:0] ONEHOT_MASK = R0_ZERO ? {{(NREGS-1){1'b1}}, 1'b0} : {NREGS{1'b1}};

  state_t            state_reg, state_next;
  logic [AW-1:0]     clr_cnt_reg;
  logic              stage_valid_reg;
  logic [AW-1:0]     stage_addr_reg;
  logic [DW-1:0]     stage_data_reg;
  logic [BW-1:0]     stage_be_reg;
  logic              clearing;
  logic              accept;
  logic [NREGS-1:0]  commit_hit;
  logic [NREGS-1:0]  clr_hit;

  assign clearing = (state_reg == CLEAR);
  assign wr_ready = (state_reg == IDLE) && !clr_req;
  assign clr_busy = clearing;
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clr_req) state_next = CLEAR;
      CLEAR:   if (clr_cnt_reg == AW'(NREGS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  regfile_addr_decoder #(.NREGS(NREGS), .AW(AW)) u_commit_dec (
    .en     (stage_valid_reg),
    .addr   (stage_addr_reg),
    .onehot (commit_hit)
  );

  regfile_addr_decoder #(.NREGS(NREGS), .AW(AW)) u_clr_dec (
    .en     (clearing),
    .addr   (clr_cnt_reg),
    .onehot (clr_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      clr_cnt_reg     <= '0;
      stage_valid_reg <= 1'b0;
      stage_addr_reg  <= '0;
      stage_data_reg  <= '0;
      stage_be_reg    <= '0;
      wr_done         <= 1'b0;
      wr_onehot       <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && clr_req)
        clr_cnt_reg <= '0;
      else if (clearing)
        clr_cnt_reg <= clr_cnt_reg + 1'b1;
      // The stage only fills in IDLE, so it is always empty while clearing.
      stage_valid_reg <= accept;
      if (accept) begin
        stage_addr_reg <= wr_addr;
        stage_data_reg <= wr_data;
        stage_be_reg   <= wr_be;
      end
      wr_done   <= stage_valid_reg;
      wr_onehot <= commit_hit & ONEHOT_MASK;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (R0_ZERO && gi == 0) begin : g_zero
        assign regs_flat[gi*DW +: DW] = '0;
      end else begin : g_live
        logic [DW-1:0] reg_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            reg_q <= '0;
          end else if (clr_hit[gi]) begin
            reg_q <= '0;
          end else if (commit_hit[gi]) begin
            for (int b = 0; b < BW; b++)
              if (stage_be_reg[b]) reg_q[b*8 +: 8] <= stage_data_reg[b*8 +: 8];
          end
        end
        assign regs_flat[gi*DW +: DW] = reg_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port: directed vector table, multi-cycle
// clear/reset sequences and randomized traffic against a behavioural model.
module tb_regfile_write_port;

  localparam int NREGS = 16;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int BW    = 4;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_valid;
  logic                wr_ready;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic [BW-1:0]       wr_be;
  logic                clr_req;
  logic                clr_busy;
  logic [NREGS-1:0]    wr_onehot;
  logic                wr_done;
  logic [NREGS*DW-1:0] regs_flat;

  regfile_write_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .wr_onehot (wr_onehot),
    .wr_done   (wr_done),
    .regs_flat (regs_flat)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: register contents, a pending write, and a clear walk index.
  logic [DW-1:0]    m_regs [NREGS];
  bit               m_pend;
  int               m_paddr;
  logic [DW-1:0]    m_pdata;
  logic [BW-1:0]    m_pbe;
  bit               m_clearing;
  int               m_cidx;
  bit               m_done;
  logic [NREGS-1:0] m_onehot;

  typedef struct {
    bit            v;
    int            a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    bit            exp_done;
    logic [15:0]   exp_oh;
    int            chk_a;
    logic [DW-1:0] exp_reg;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(bit v, int a, logic [DW-1:0] d, logic [BW-1:0] be,
                              bit ed, logic [15:0] eo, int ca, logic [DW-1:0] er);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.be = be;
    r.exp_done = ed; r.exp_oh = eo; r.chk_a = ca; r.exp_reg = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [NREGS*DW-1:0] act, input logic [NREGS*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREGS*DW-1:0] model_flat();
    logic [NREGS*DW-1:0] f;
    for (int k = 0; k < NREGS; k++) f[k*DW +: DW] = m_regs[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
    m_pend = 0; m_clearing = 0; m_cidx = 0; m_done = 0; m_onehot = '0;
  endtask

  task automatic model_edge(input bit v, input int a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be, input bit clr);
    logic [DW-1:0] mask;
    m_done = 0;
    m_onehot = '0;
    if (m_clearing) begin
      m_regs[m_cidx] = '0;
      m_cidx++;
      if (m_cidx == NREGS) m_clearing = 0;
    end else begin
      if (m_pend) begin
        mask = '0;
        for (int b = 0; b < BW; b++) if (be_bit(m_pbe, b)) mask |= (32'hFF << (8 * b));
        if (!(R0Z && m_paddr == 0)) begin
          m_regs[m_paddr] = (m_regs[m_paddr] & ~mask) | (m_pdata & mask);
          m_onehot = 16'(1) << m_paddr;
        end
        m_done = 1;
        m_pend = 0;
      end
      if (clr) begin
        m_clearing = 1;
        m_cidx = 0;
      end else if (v) begin
        m_pend = 1; m_paddr = a; m_pdata = d; m_pbe = be;
      end
    end
  endtask

  function automatic bit be_bit(input logic [BW-1:0] be, input int b);
    return be[b];
  endfunction

  // One clock cycle: drive, check ready, clock, update model, compare everything.
  task automatic step(input bit v, input int a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be, input bit clr);
    bit exp_ready;
    wr_valid = v; wr_addr = a[AW-1:0]; wr_data = d; wr_be = be; clr_req = clr;
    exp_ready = !m_clearing && !clr;
    #1;
    chk("wr_ready", wr_ready, exp_ready);
    if (v && exp_ready) $display("txn write addr=%0d data=%h be=%h", a, d, be);
    if (clr && !m_clearing) $display("txn clear request");
    @(posedge clk);
    model_edge(v, a, d, be, clr);
    #1;
    chk("wr_done", wr_done, m_done);
    chk("wr_onehot", wr_onehot, m_onehot);
    chk("clr_busy", clr_busy, m_clearing);
    chk("regs_flat", regs_flat, model_flat());
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_valid = 0; wr_addr = '0; wr_data = '0; wr_be = '0; clr_req = 0;
    model_reset();
    #1;
    chk("rst_regs", regs_flat, '0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_onehot", wr_onehot, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", wr_ready, 1);
  endtask

  initial begin
    int busy;
    vecs[0] = mk(1, 5, 32'hDEADBEEF, 4'hF, 0, 16'h0000, 5, 32'h0);
    vecs[1] = mk(0, 0, 32'h0,        4'h0, 1, 16'h0020, 5, 32'hDEADBEEF);
    vecs[2] = mk(0, 0, 32'h0,        4'h0, 0, 16'h0000, 5, 32'hDEADBEEF);
    vecs[3] = mk(1, 3, 32'h11223344, 4'hF, 0, 16'h0000, 3, 32'h0);
    vecs[4] = mk(1, 3, 32'hAABBCCDD, 4'h5, 1, 16'h0008, 3, 32'h11223344);
    vecs[5] = mk(0, 0, 32'h0,        4'h0, 1, 16'h0008, 3, 32'h11BB33DD);
    vecs[6] = mk(0, 0, 32'h0,        4'h0, 0, 16'h0000, 3, 32'h11BB33DD);
    vecs[7] = mk(1, 0, 32'hFFFFFFFF, 4'hF, 0, 16'h0000, 0, 32'h0);
    vecs[8] = mk(0, 0, 32'h0,        4'h0, 1, R0Z ? 16'h0000 : 16'h0001, 0, R0Z ? 32'h0 : 32'hFFFFFFFF);
    vecs[9] = mk(0, 0, 32'h0,        4'h0, 0, 16'h0000, 0, R0Z ? 32'h0 : 32'hFFFFFFFF);

    do_reset();

    // Directed table: single write, byte-merge on same address, register 0 write.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].be, 0);
      chk($sformatf("vec%0d_done", i), wr_done, vecs[i].exp_done);
      chk($sformatf("vec%0d_onehot", i), wr_onehot, vecs[i].exp_oh);
      chk($sformatf("vec%0d_reg", i), regs_flat[vecs[i].chk_a*DW +: DW], vecs[i].exp_reg);
    end

    // Fill all registers, then clear with a colliding write request.
    for (int k = 0; k < NREGS; k++) step(1, k, 32'h1000_0000 + k, 4'hF, 0);
    idle();
    step(1, 7, 32'hBAD0BAD0, 4'hF, 1);
    busy = clr_busy ? 1 : 0;
    for (int j = 1; j <= 40; j++) begin
      idle();
      chk($sformatf("clr_order%0d", j), regs_flat[(j-1)*DW +: DW], '0);
      if (!clr_busy) break;
      busy++;
      if (j == 40) chk("clr_timeout", 1, 0);
    end
    chk("clr_len", busy, NREGS);
    chk("ready_after_clr", wr_ready, 1);

    // Reset in CLEAR cycle 7.
    for (int k = 1; k < 4; k++) step(1, k, 32'h5A5A0000 + k, 4'hF, 0);
    idle();
    step(0, 0, '0, '0, 1);
    for (int j = 0; j < 6; j++) idle();
    rst_n = 1'b0;
    #1;
    chk("midclr_regs", regs_flat, '0);
    chk("midclr_busy", clr_busy, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Reset with a staged write: the write is dropped.
    step(1, 4, 32'h44444444, 4'hF, 0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_stage_done", wr_done, 0);
    chk("rst_stage_reg", regs_flat[4*DW +: DW], '0);
    rst_n = 1'b1;
    step(1, 9, 32'hCAFEF00D, 4'hF, 0);
    idle();
    chk("post_rst_done", wr_done, 1);
    chk("post_rst_reg9", regs_flat[9*DW +: DW], 32'hCAFEF00D);

    // Write staged right before clr_req rises still commits; CLEAR zeroes reg 2 third.
    step(1, 2, 32'h22222222, 4'hF, 0);
    step(0, 0, '0, '0, 1);
    chk("pre_clr_done", wr_done, 1);
    chk("pre_clr_onehot", wr_onehot, 16'h0004);
    chk("pre_clr_reg2", regs_flat[2*DW +: DW], 32'h22222222);
    idle(); idle();
    chk("clr2_kept", regs_flat[2*DW +: DW], 32'h22222222);
    idle();
    chk("clr2_zeroed", regs_flat[2*DW +: DW], '0);
    for (int j = 0; j < 20 && clr_busy; j++) idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 1), $urandom_range(0, NREGS - 1), $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
    for (int j = 0; j < 20; j++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
